// File: rtl/stage_f.sv
// Instruction fetch stage.
// Issues in-order fetch requests to instruction memory, tracks the PC and
// mode of every outstanding request, buffers returned instructions in a
// 2-entry FIFO toward decode, and handles execute-stage redirects by
// flushing the buffer and discarding responses that are still in flight.
// Requests are only issued while the buffer is guaranteed room for every
// live (non-discarded) response, so the FIFO can never overflow.
module stage_f #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        ARM_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        armE,
  input  logic        StallD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ValidF,
  output logic [31:0] RDF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        armF
);

  // One buffered instruction toward decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        arm;
  } fetch_entry_t;

  // One outstanding memory request.
  typedef struct packed {
    logic [31:0] pc;
    logic        arm;
  } flight_entry_t;

  // Fetch address and mode.
  logic [31:0]   pc_r;
  logic          arm_r;

  // Decode-side FIFO.
  fetch_entry_t  fifo_r [2];
  logic          fifo_rd_r;
  logic          fifo_wr_r;
  logic [1:0]    occ_r;

  // In-flight request queue.
  flight_entry_t flight_r [2];
  logic          flight_rd_r;
  logic          flight_wr_r;
  logic [1:0]    inflight_r;
  logic [1:0]    drop_r;

  // Combinational control.
  logic [1:0]    live_s;
  logic          req_valid_s;
  logic          handshake_s;
  logic          rsp_take_s;
  logic          rsp_push_s;
  logic          consume_s;
  logic [31:0]   redirect_pc_s;
  logic [31:0]   next_pc_s;
  flight_entry_t flight_head_s;
  fetch_entry_t  fifo_head_s;
  fetch_entry_t  fifo_new_s;
  flight_entry_t flight_new_s;

  // Word-align an address.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Request credit, handshake and response/consume qualification.
  always_comb begin
    live_s        = inflight_r - drop_r;
    redirect_pc_s = align_word(PCTargetE);
    next_pc_s     = pc_r + 32'd4;
    flight_head_s = flight_r[flight_rd_r];
    fifo_head_s   = fifo_r[fifo_rd_r];

    // A request is only offered if every live response already has a FIFO
    // slot reserved; discarded responses never occupy the FIFO.
    req_valid_s = rst_n & ~PCSrcE & (inflight_r < 2'd2)
                & (({1'b0, live_s} + {1'b0, occ_r}) < 3'd2);
    handshake_s = req_valid_s & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take_s  = imem_rsp_valid & (inflight_r != 2'd0);
    rsp_push_s  = rsp_take_s & (drop_r == 2'd0) & ~PCSrcE;

    // A redirect turns any same-cycle consume into a no-op.
    consume_s   = (occ_r != 2'd0) & ~StallD & ~PCSrcE;

    fifo_new_s.instr = imem_rsp_data;
    fifo_new_s.pc    = flight_head_s.pc;
    fifo_new_s.arm   = flight_head_s.arm;

    flight_new_s.pc  = pc_r;
    flight_new_s.arm = arm_r;
  end

  // Fetch PC and mode: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r  <= align_word(RESET_PC);
      arm_r <= ARM_RESET;
    end else if (PCSrcE) begin
      pc_r  <= redirect_pc_s;
      arm_r <= armE;
    end else if (handshake_s) begin
      pc_r  <= next_pc_s;
      arm_r <= arm_r;
    end else begin
      pc_r  <= pc_r;
      arm_r <= arm_r;
    end
  end

  // In-flight queue storage and pointers: push on handshake, pop on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        flight_r[i] <= '0;
      end
      flight_rd_r <= 1'b0;
      flight_wr_r <= 1'b0;
    end else begin
      if (handshake_s) begin
        flight_r[flight_wr_r] <= flight_new_s;
        flight_wr_r           <= ~flight_wr_r;
      end
      if (rsp_take_s) begin
        flight_rd_r <= ~flight_rd_r;
      end
    end
  end

  // Outstanding request count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 2'd0;
    end else begin
      case ({handshake_s, rsp_take_s})
        2'b10:   inflight_r <= inflight_r + 2'd1;
        2'b01:   inflight_r <= inflight_r - 2'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Count of outstanding responses that belong to a squashed fetch stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= 2'd0;
    end else if (PCSrcE) begin
      // Everything still outstanding after this cycle's response is stale.
      drop_r <= inflight_r - {1'b0, rsp_take_s};
    end else if (rsp_take_s && (drop_r != 2'd0)) begin
      drop_r <= drop_r - 2'd1;
    end else begin
      drop_r <= drop_r;
    end
  end

  // Decode FIFO: flush on redirect, otherwise push responses and pop on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_r[i] <= '0;
      end
      fifo_rd_r <= 1'b0;
      fifo_wr_r <= 1'b0;
      occ_r     <= 2'd0;
    end else if (PCSrcE) begin
      fifo_rd_r <= 1'b0;
      fifo_wr_r <= 1'b0;
      occ_r     <= 2'd0;
    end else begin
      if (rsp_push_s) begin
        fifo_r[fifo_wr_r] <= fifo_new_s;
        fifo_wr_r         <= ~fifo_wr_r;
      end
      if (consume_s) begin
        fifo_rd_r <= ~fifo_rd_r;
      end
      case ({rsp_push_s, consume_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Output drive: memory request and FIFO head, zeroed while the FIFO is empty.
  always_comb begin
    imem_req_valid = req_valid_s;
    imem_addr      = pc_r;
    ValidF         = (occ_r != 2'd0);
    if (ValidF) begin
      RDF      = fifo_head_s.instr;
      PCF      = fifo_head_s.pc;
      PCPlus4F = fifo_head_s.pc + 32'd4;
      armF     = fifo_head_s.arm;
    end else begin
      RDF      = 32'd0;
      PCF      = 32'd0;
      PCPlus4F = 32'd0;
      armF     = arm_r;
    end
  end

endmodule

// File: doc/stage_f.md
STAGE_F -- requirements
Module: stage_f

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL provide parameter ARM_RESET, default 1'b0, instruction-set mode on reset (1 = ARM, 0 = RISC-V).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  async active-low reset.
- PCSrcE  in  1  redirect request from execute.
- PCTargetE  in  32  redirect target.
- armE  in  1  mode after redirect.
- StallD  in  1  decode not accepting this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address.
- imem_rsp_valid  in  1  in-order response valid; no back-pressure.
- imem_rsp_data  in  32  instruction word.
- ValidF  out  1  head entry valid toward decode.
- RDF  out  32  head instruction.
- PCF  out  32  head instruction address.
- PCPlus4F  out  32  PCF + 4.
- armF  out  1  head instruction mode.

Function
REQ-005 SHALL hold a fetch PC, a mode bit, a 2-entry FIFO of {instr, pc, arm}, a 2-deep in-flight PC/mode queue, an inflight count (0..2) and a drop count (0..2).
REQ-006 SHALL define live = inflight - drop.
REQ-007 SHALL drive imem_req_valid = rst_n & ~PCSrcE & (inflight < 2) & (live + occupancy < 2), combinationally.
REQ-008 SHALL drive imem_addr = fetch PC, with bits [1:0] always 0.
REQ-009 SHALL treat requests as non-binding until imem_req_ready; withdrawal without ready is legal.
REQ-010 On handshake (valid & ready): SHALL push {PC, mode} to the in-flight queue, increment inflight, and set PC to PC + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-011 On imem_rsp_valid with drop = 0 and no PCSrcE: SHALL pop the in-flight queue, decrement inflight, and push {imem_rsp_data, popped pc, popped mode} to the FIFO.
REQ-012 On imem_rsp_valid with drop > 0: SHALL pop the in-flight queue, decrement inflight and drop, and discard the data.
REQ-013 SHALL drive ValidF = FIFO not empty; RDF, PCF and armF from the head entry; PCPlus4F = PCF + 4, with wrap.
REQ-014 SHALL drive RDF, PCF and PCPlus4F to 0 and armF to the mode bit while the FIFO is empty.
REQ-015 On ValidF & ~StallD: SHALL pop the FIFO head; latency from response to ValidF is 1 cycle.
REQ-016 On PCSrcE: SHALL set PC to {PCTargetE[31:2], 2'b00} and mode to armE, and flush the FIFO.
REQ-017 On PCSrcE: SHALL set drop to the inflight count remaining after any same-cycle response.
REQ-018 On PCSrcE: a same-cycle response SHALL be discarded, and a same-cycle consume SHALL be a no-op.
REQ-019 SHALL allow push and pop in the same cycle; occupancy is then unchanged, with order preserved.
REQ-020 SHALL never overflow the FIFO, by the credit rule of REQ-007.
REQ-021 A response arriving when inflight = 0 is a protocol error: SHALL ignore it and leave state unchanged.
REQ-022 A redirect target equal to the current PC SHALL still flush.

Reset
REQ-023 While rst_n = 0 (async assert), SHALL set PC = RESET_PC, mode = ARM_RESET, FIFO empty, inflight = 0 and drop = 0.
REQ-024 While rst_n = 0, SHALL drive ValidF = 0 and imem_req_valid = 0.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered entries, and ignore responses while rst_n = 0.
REQ-026 SHALL issue the first request in the first cycle with rst_n = 1.

Verification
REQ-027 Reset release, ready=1, 1-cycle response latency, StallD=0 -> imem_addr 0,4,8...; ValidF from cycle 2 with PCF 0,4,8 and PCPlus4F 4,8,C.
REQ-028 StallD=1 held, ready=1 -> at most 2 requests issued, ValidF=1, head PCF=0 held stable; release -> PCF 0 then 4, no loss or duplication.
REQ-029 Two requests outstanding, PCSrcE=1 with PCTargetE=32'h0000_1006 and armE=1 -> next imem_addr=32'h1004; next 2 responses dropped; first ValidF shows PCF=32'h1004, armF=1.
REQ-030 PCSrcE in the same cycle as imem_rsp_valid and ValidF&~StallD -> response discarded, FIFO empty next cycle, drop equals remaining inflight.
REQ-031 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4F of the FFFF_FFFC entry = 0.
REQ-032 rst_n pulsed low asynchronously with FIFO full and inflight=2 -> ValidF=0 immediately; after release, fetch restarts at RESET_PC and stale responses are not delivered.
